// File: rtl/mips_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   mem_op_e     : memory operation encodings carried on ex_mem_op
//   exc_code_e   : exception codes reported on exc_code
//   lsu_state_e  : LSU control states
//   decode_mem_op: maps a raw 4-bit op code onto mem_op_e (unknown -> NONE)
package mips_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        EXC_ALIGN_LD = 2'd0,
        EXC_ALIGN_ST = 2'd1,
        EXC_BUS_ERR  = 2'd2,
        EXC_TIMEOUT  = 2'd3
    } exc_code_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lsu_state_e;

    // Reserved encodings behave exactly like a non-memory op.
    function automatic mem_op_e decode_mem_op(input logic [3:0] code);
        mem_op_e op;
        case (code)
            4'd1:    op = MEM_LB;
            4'd2:    op = MEM_LBU;
            4'd3:    op = MEM_LH;
            4'd4:    op = MEM_LHU;
            4'd5:    op = MEM_LW;
            4'd6:    op = MEM_SB;
            4'd7:    op = MEM_SH;
            4'd8:    op = MEM_SW;
            default: op = MEM_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane logic for the load/store unit (purely combinational).
//   op_i        : decoded memory operation
//   addr_lo_i   : effective address bits [1:0]
//   wdata_i     : raw store data (rt)
//   rdata_i     : raw load data from memory
//   be_o        : byte enables for the bus
//   wdata_o     : store data replicated onto every lane
//   misalign_o  : access violates its natural alignment
//   is_mem_o    : op touches memory
//   is_load_o   : op is a load
//   load_data_o : selected and sign/zero-extended load result
module lsu_lane_align
    import mips_pkg::*;
(
    input  mem_op_e     op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    output logic        is_mem_o,
    output logic        is_load_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Little-endian lane selection: byte k lives in bits [8k+7:8k].
    assign byte_s = rdata_i[8*addr_lo_i +: 8];
    assign half_s = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Per-op lane enables, store replication, alignment and load extension
    always_comb begin
        be_o        = 4'b1111;
        wdata_o     = wdata_i;
        misalign_o  = 1'b0;
        is_mem_o    = 1'b1;
        is_load_o   = 1'b0;
        load_data_o = 32'd0;
        case (op_i)
            MEM_LB: begin
                is_load_o   = 1'b1;
                load_data_o = {{24{byte_s[7]}}, byte_s};
            end
            MEM_LBU: begin
                is_load_o   = 1'b1;
                load_data_o = {24'd0, byte_s};
            end
            MEM_LH: begin
                is_load_o   = 1'b1;
                misalign_o  = addr_lo_i[0];
                load_data_o = {{16{half_s[15]}}, half_s};
            end
            MEM_LHU: begin
                is_load_o   = 1'b1;
                misalign_o  = addr_lo_i[0];
                load_data_o = {16'd0, half_s};
            end
            MEM_LW: begin
                is_load_o   = 1'b1;
                misalign_o  = (addr_lo_i != 2'b00);
                load_data_o = rdata_i;
            end
            MEM_SB: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            MEM_SH: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                misalign_o = addr_lo_i[0];
            end
            MEM_SW: begin
                misalign_o = (addr_lo_i != 2'b00);
            end
            default: begin
                is_mem_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit.
// Takes the EX-stage ALU result as effective address (or passthrough data for
// non-memory ops), runs a held req/ack access to data memory with byte lanes
// and load extension, and emits one-cycle writeback or exception pulses.
//   clk, rst                : clock, synchronous active-high reset
//   ex_*                    : EX/MEM instruction (valid, op, addr, data, rd, we)
//   flush                   : kill the instruction at the EX/MEM boundary
//   ex_ready, stall         : combinational handshake back to the pipeline
//   dm_req/we/addr/be/wdata : data-memory request (registered, held until ack)
//   dm_ack/rdata/err        : data-memory response
//   wb_valid/we/rd/data     : writeback pulse
//   exc_valid/code/addr     : exception pulse
module lsu_mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [3:0]        ex_mem_op,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_we,
    input  logic              flush,
    output logic              ex_ready,
    output logic              stall,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata,
    input  logic              dm_err,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              exc_valid,
    output logic [1:0]        exc_code,
    output logic [ADDR_W-1:0] exc_addr
);

    localparam int unsigned TIMER_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    // Control state
    lsu_state_e        state_q, state_d;
    logic              kill_q, kill_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    mem_op_e           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        rd_q, rd_d;

    // Registered outputs
    logic              dm_req_q, dm_req_d;
    logic              dm_we_q, dm_we_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [3:0]        dm_be_q, dm_be_d;
    logic [31:0]       dm_wdata_q, dm_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_we_q, wb_we_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              exc_valid_q, exc_valid_d;
    exc_code_e         exc_code_q, exc_code_d;
    logic [ADDR_W-1:0] exc_addr_q, exc_addr_d;

    // Lane logic inputs/outputs
    mem_op_e     ex_op_s;
    mem_op_e     align_op_s;
    logic [1:0]  align_addr_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic        misalign_s;
    logic        is_mem_s;
    logic        is_load_s;
    logic [31:0] load_data_s;
    logic        capture_s;
    logic        kill_now_s;

    assign ex_op_s   = decode_mem_op(ex_mem_op);
    assign capture_s = ex_valid & ex_ready & ~flush;
    // A flush on the ack edge itself also kills the result.
    assign kill_now_s = kill_q | flush;

    // The lane block decodes the incoming op while idle and the held op while
    // an access is outstanding, so one instance serves issue and completion.
    assign align_op_s   = (state_q == IDLE) ? ex_op_s : op_q;
    assign align_addr_s = (state_q == IDLE) ? ex_addr[1:0] : addr_q[1:0];

    lsu_lane_align u_lane_align (
        .op_i        (align_op_s),
        .addr_lo_i   (align_addr_s),
        .wdata_i     (ex_wdata),
        .rdata_i     (dm_rdata),
        .be_o        (be_s),
        .wdata_o     (wdata_s),
        .misalign_o  (misalign_s),
        .is_mem_o    (is_mem_s),
        .is_load_o   (is_load_s),
        .load_data_o (load_data_s)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        timer_d     = timer_q;
        op_d        = op_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        dm_req_d    = dm_req_q;
        dm_we_d     = dm_we_q;
        dm_addr_d   = dm_addr_q;
        dm_be_d     = dm_be_q;
        dm_wdata_d  = dm_wdata_q;
        wb_valid_d  = 1'b0;
        wb_we_d     = wb_we_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        exc_valid_d = 1'b0;
        exc_code_d  = exc_code_q;
        exc_addr_d  = exc_addr_q;

        case (state_q)
            IDLE: begin
                if (!capture_s) begin
                    state_d = IDLE;
                end else if (!is_mem_s) begin
                    // Passthrough: ALU result goes straight to writeback.
                    wb_valid_d = 1'b1;
                    wb_we_d    = ex_reg_we;
                    wb_rd_d    = ex_rd;
                    wb_data_d  = ex_addr[31:0];
                end else if (misalign_s) begin
                    exc_valid_d = 1'b1;
                    exc_code_d  = is_load_s ? EXC_ALIGN_LD : EXC_ALIGN_ST;
                    exc_addr_d  = ex_addr;
                end else begin
                    state_d    = BUSY;
                    kill_d     = 1'b0;
                    timer_d    = '0;
                    op_d       = ex_op_s;
                    addr_d     = ex_addr;
                    rd_d       = ex_rd;
                    dm_req_d   = 1'b1;
                    dm_we_d    = ~is_load_s;
                    dm_addr_d  = {ex_addr[ADDR_W-1:2], 2'b00};
                    dm_be_d    = be_s;
                    dm_wdata_d = wdata_s;
                end
            end
            BUSY: begin
                kill_d = kill_now_s;
                if (dm_ack) begin
                    // Ack beats a timeout landing on the same edge.
                    state_d  = IDLE;
                    dm_req_d = 1'b0;
                    if (kill_now_s) begin
                        wb_valid_d = 1'b0;
                    end else if (dm_err) begin
                        exc_valid_d = 1'b1;
                        exc_code_d  = EXC_BUS_ERR;
                        exc_addr_d  = addr_q;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = is_load_s;
                        wb_rd_d    = rd_q;
                        wb_data_d  = is_load_s ? load_data_s : 32'd0;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    // Timeout is reported even for a killed access.
                    state_d     = IDLE;
                    dm_req_d    = 1'b0;
                    exc_valid_d = 1'b1;
                    exc_code_d  = EXC_TIMEOUT;
                    exc_addr_d  = addr_q;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                dm_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            kill_q      <= 1'b0;
            timer_q     <= '0;
            op_q        <= MEM_NONE;
            addr_q      <= '0;
            rd_q        <= 5'd0;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_be_q     <= 4'd0;
            dm_wdata_q  <= 32'd0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            exc_valid_q <= 1'b0;
            exc_code_q  <= EXC_ALIGN_LD;
            exc_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            timer_q     <= timer_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            dm_req_q    <= dm_req_d;
            dm_we_q     <= dm_we_d;
            dm_addr_q   <= dm_addr_d;
            dm_be_q     <= dm_be_d;
            dm_wdata_q  <= dm_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            exc_valid_q <= exc_valid_d;
            exc_code_q  <= exc_code_d;
            exc_addr_q  <= exc_addr_d;
        end
    end

    assign ex_ready  = (state_q == IDLE);
    assign stall     = ~ex_ready;
    assign dm_req    = dm_req_q;
    assign dm_we     = dm_we_q;
    assign dm_addr   = dm_addr_q;
    assign dm_be     = dm_be_q;
    assign dm_wdata  = dm_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign exc_valid = exc_valid_q;
    assign exc_code  = exc_code_q;
    assign exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized self-checking bench for lsu_mem_stage against a transaction-level
// reference model.
module tb_lsu_mem_stage;

    localparam int T = 4;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        ex_reg_we;
    logic        flush;
    logic        ex_ready;
    logic        stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        dm_err;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_code;
    logic [31:0] exc_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.TIMEOUT_CYC(T), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_op(ex_mem_op), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .flush(flush),
        .ex_ready(ex_ready), .stall(stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_addr(exc_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_is_mem(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

    function automatic bit m_is_ld(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic int m_size(input logic [3:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic bit m_misaligned(input logic [3:0] op, input logic [31:0] a);
        return (int'(a % 32'd4) % m_size(op)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
        if (op == OP_SB) return 4'(2 ** int'(a % 32'd4));
        if (op == OP_SH) return (a % 32'd4 >= 32'd2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] w);
        logic [31:0] b, h;
        b = w % 32'd256;
        h = w % 32'd65536;
        if (op == OP_SB) return b * 32'h0101_0101;
        if (op == OP_SH) return h * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd / (32'd1 << (8 * (a % 32'd4)))) % 32'd256;
        h = (rd / ((a % 32'd4 >= 32'd2) ? 32'd65536 : 32'd1)) % 32'd65536;
        case (op)
            OP_LB:   return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            OP_LBU:  return b;
            OP_LH:   return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            OP_LHU:  return h;
            default: return rd;
        endcase
    endfunction

    // One instruction through the stage. Starts and ends on a negedge with
    // the input bus idle. ack_dly: BUSY cycles before dm_ack (>= T means none).
    task automatic run_txn(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd,
                           input logic rwe, input logic cap_flush,
                           input int ack_dly, input logic err,
                           input logic [31:0] rdata, input int flush_idx);
        int  c;
        bit  killed;
        bit  tmo;
        chk("ready_pre", ex_ready, 1);
        ex_valid = 1'b1; ex_mem_op = op; ex_addr = addr; ex_wdata = wd;
        ex_rd = rd; ex_reg_we = rwe; flush = cap_flush;
        @(posedge clk); @(negedge clk);
        ex_valid = 1'b0; flush = 1'b0;
        if (cap_flush) begin
            chk("flush_wb", wb_valid, 0);
            chk("flush_exc", exc_valid, 0);
            chk("flush_req", dm_req, 0);
            chk("flush_ready", ex_ready, 1);
            return;
        end
        if (!m_is_mem(op)) begin
            chk("none_wbv", wb_valid, 1);
            chk("none_wbwe", wb_we, rwe);
            chk("none_wbd", wb_data, addr);
            chk("none_rd", wb_rd, rd);
            chk("none_exc", exc_valid, 0);
            chk("none_req", dm_req, 0);
            chk("none_ready", ex_ready, 1);
            return;
        end
        if (m_misaligned(op, addr)) begin
            chk("al_exc", exc_valid, 1);
            chk("al_code", exc_code, m_is_ld(op) ? 0 : 1);
            chk("al_addr", exc_addr, addr);
            chk("al_wb", wb_valid, 0);
            chk("al_req", dm_req, 0);
            chk("al_ready", ex_ready, 1);
            return;
        end
        chk("iss_req", dm_req, 1);
        chk("iss_we", dm_we, !m_is_ld(op));
        chk("iss_addr", dm_addr, addr - (addr % 32'd4));
        chk("iss_be", dm_be, m_be(op, addr));
        if (!m_is_ld(op)) chk("iss_wdata", dm_wdata, m_wdata(op, wd));
        chk("iss_stall", stall, 1);
        tmo    = (ack_dly >= T);
        c      = tmo ? T - 1 : ack_dly;
        killed = 1'b0;
        for (int k = 0; k <= c; k++) begin
            if (k > 0) begin
                chk("busy_req", dm_req, 1);
                chk("busy_addr", dm_addr, addr - (addr % 32'd4));
                chk("busy_be", dm_be, m_be(op, addr));
                chk("busy_wb", wb_valid, 0);
                chk("busy_exc", exc_valid, 0);
                chk("busy_stall", stall, 1);
            end
            dm_ack   = (k == ack_dly);
            dm_err   = dm_ack ? err : 1'($urandom_range(0, 1));
            dm_rdata = dm_ack ? rdata : $urandom;
            flush    = (k == flush_idx);
            if (flush) killed = 1'b1;
            // Junk upstream traffic must be ignored while stalled.
            ex_valid  = 1'($urandom_range(0, 1));
            ex_mem_op = 4'($urandom_range(0, 15));
            ex_addr   = $urandom;
            ex_rd     = 5'($urandom);
            @(posedge clk); @(negedge clk);
        end
        dm_ack = 1'b0; dm_err = 1'b0; flush = 1'b0; ex_valid = 1'b0;
        chk("done_req", dm_req, 0);
        chk("done_ready", ex_ready, 1);
        if (tmo) begin
            chk("tmo_exc", exc_valid, 1);
            chk("tmo_code", exc_code, 3);
            chk("tmo_wb", wb_valid, 0);
        end else if (killed) begin
            chk("kill_wb", wb_valid, 0);
            chk("kill_exc", exc_valid, 0);
        end else if (err) begin
            chk("berr_exc", exc_valid, 1);
            chk("berr_code", exc_code, 2);
            chk("berr_wb", wb_valid, 0);
        end else begin
            chk("ack_wbv", wb_valid, 1);
            chk("ack_exc", exc_valid, 0);
            chk("ack_wbwe", wb_we, m_is_ld(op));
            chk("ack_rd", wb_rd, rd);
            if (m_is_ld(op)) chk("ack_data", wb_data, m_load(op, addr, rdata));
        end
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_mem_op = 4'd0; ex_addr = 32'd0;
        ex_wdata = 32'd0; ex_rd = 5'd0; ex_reg_we = 1'b0; flush = 1'b0;
        dm_ack = 1'b0; dm_rdata = 32'd0; dm_err = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_ready", ex_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_req", dm_req, 0);
        chk("rst_be", dm_be, 0);
        chk("rst_wb", wb_valid, 0);
        chk("rst_exc", exc_valid, 0);
        chk("rst_wbd", wb_data, 0);
        rst = 1'b0;

        // Directed cases
        run_txn(OP_NONE, 32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b0, 0, 1'b0, 32'd0, -1);
        run_txn(4'd13, 32'hCAFE_0001, 32'd0, 5'd9, 1'b0, 1'b0, 0, 1'b0, 32'd0, -1);
        run_txn(OP_SB, 32'h0000_0103, 32'h0000_00A5, 5'd1, 1'b0, 1'b0, 3, 1'b0, 32'd0, -1);
        run_txn(OP_SH, 32'h0000_0202, 32'h1234_BEEF, 5'd1, 1'b0, 1'b0, 0, 1'b0, 32'd0, -1);
        run_txn(OP_LB, 32'h0000_0102, 32'd0, 5'd7, 1'b0, 1'b0, 1, 1'b0, 32'h0080_0000, -1);
        run_txn(OP_LBU, 32'h0000_0102, 32'd0, 5'd8, 1'b0, 1'b0, 0, 1'b0, 32'h0080_0000, -1);
        run_txn(OP_LH, 32'h0000_0106, 32'd0, 5'd8, 1'b0, 1'b0, 0, 1'b0, 32'h9234_0000, -1);
        run_txn(OP_LW, 32'h0000_0102, 32'd0, 5'd3, 1'b0, 1'b0, 0, 1'b0, 32'd0, -1);
        run_txn(OP_SH, 32'h0000_0101, 32'd0, 5'd3, 1'b0, 1'b0, 0, 1'b0, 32'd0, -1);
        run_txn(OP_LW, 32'h0000_0200, 32'd0, 5'd4, 1'b0, 1'b0, 10, 1'b0, 32'd0, -1);
        run_txn(OP_LW, 32'h0000_0200, 32'd0, 5'd4, 1'b0, 1'b0, T - 1, 1'b0, 32'h1357_9BDF, -1);
        run_txn(OP_LW, 32'h0000_0204, 32'd0, 5'd4, 1'b0, 1'b0, 2, 1'b1, 32'd0, -1);
        run_txn(OP_LH, 32'h0000_0302, 32'd0, 5'd6, 1'b0, 1'b0, 3, 1'b0, 32'hFFFF_FFFF, 1);
        run_txn(OP_SW, 32'h0000_0300, 32'h0BAD_F00D, 5'd6, 1'b0, 1'b1, 0, 1'b0, 32'd0, -1);

        // Reset in the middle of an outstanding access
        ex_valid = 1'b1; ex_mem_op = OP_LW; ex_addr = 32'h0000_0400; ex_rd = 5'd2;
        @(posedge clk); @(negedge clk);
        ex_valid = 1'b0;
        chk("mid_req", dm_req, 1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_req", dm_req, 0);
        chk("mid_rst_ready", ex_ready, 1);
        chk("mid_rst_wb", wb_valid, 0);
        chk("mid_rst_exc", exc_valid, 0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            logic [3:0]  op;
            int          fidx;
            op   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
            fidx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_txn(op, $urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0), int'($urandom_range(0, 5)),
                    ($urandom_range(0, 5) == 0), $urandom, fidx);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // wb_valid and exc_valid must never coincide
    always @(negedge clk) begin
        if (!rst && wb_valid && exc_valid) chk("wb_exc_excl", {wb_valid, exc_valid}, 2'b00);
    end

endmodule
